ripple_down_timer: RTL and testbench

//   Loadable WIDTH-bit down-counter/timer. It complements the existing up counter.

---
 rtl/counter_pkg.sv | 5 +
 rtl/down_count_core.sv | 24 ++
 rtl/ripple_down_timer.sv | 84 ++++++++
 tb/tb_ripple_down_timer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding and default width for the counter blocks.
package counter_pkg;
   localparam int WIDTH_DEF = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/down_count_core.sv
// down_count_core: loadable down-count register with zero/one detect; clr beats load beats decrement.
import counter_pkg::*;
module down_count_core #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] cnt,
   output logic             is_zero,
   output logic             is_one
);
   logic [WIDTH-1:0] cnt_q, cnt_d;
   assign is_zero = cnt_q == '0;
   assign is_one  = cnt_q == WIDTH'(1);
   assign cnt     = cnt_q;
   always_comb cnt_d = clr ? '0 : load ? load_value : (dec && !is_zero) ? cnt_q - WIDTH'(1) : cnt_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
endmodule

// File: rtl/ripple_down_timer.sv
// ripple_down_timer: loadable down-counter with one-cycle terminal-count pulse.
// AUTO_RELOAD_EN: restart from the last loaded value instead of returning to IDLE.
import counter_pkg::*;
module ripple_down_timer #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             busy
);
   state_t           state_q, state_d;
   logic             tc_q, tc_d, busy_q, busy_d;
   logic             ld, dec, is_zero, is_one;
   logic [WIDTH-1:0] ld_val;
`ifdef AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst)                                       reload_q <= '0;
      else if (state_q == IDLE && load_valid && !clr) reload_q <= load_value;
`endif
   down_count_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .load       (ld),
      .dec        (dec),
      .load_value (ld_val),
      .cnt        (out),
      .is_zero    (is_zero),
      .is_one     (is_one)
   );
   always_comb begin
      state_d = state_q;
      ld      = 1'b0;
      dec     = 1'b0;
      ld_val  = load_value;
      case (state_q)
         IDLE: begin
            ld = load_valid;
            if (load_valid) state_d = (load_value == '0) ? DONE : RUN;
         end
         RUN: begin
            dec = en & ~is_zero;
            if (en && is_one) state_d = DONE;
         end
         DONE: begin
`ifdef AUTO_RELOAD_EN
            // a zero reload parks in DONE so tc stays asserted
            if (reload_q != '0) begin
               ld      = 1'b1;
               ld_val  = reload_q;
               state_d = RUN;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
      if (clr) state_d = IDLE;
      tc_d   = state_d == DONE;
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= IDLE;
         tc_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tc_q    <= tc_d;
         busy_q  <= busy_d;
      end
   assign load_ready = state_q == IDLE;
   assign tc         = tc_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_ripple_down_timer.sv
// tb_ripple_down_timer: directed vector table plus hand sequences for reset, max load and auto-reload.
module tb_ripple_down_timer;
   logic       clk = 1'b0, rst = 1'b0, load_valid = 1'b0, en = 1'b0, clr = 1'b0;
   logic [3:0] load_value = 4'd0;
   logic       load_ready, tc, busy;
   logic [3:0] out;
   int         errors = 0, checks = 0;

   typedef struct {
      logic       lv;
      logic [3:0] val;
      logic       en;
      logic       clr;
      logic [3:0] o;
      logic       t;
      logic       b;
      logic       r;
   } vec_t;
   vec_t vt[27];

   ripple_down_timer #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_value (load_value),
      .en         (en),
      .clr        (clr),
      .out        (out),
      .tc         (tc),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic lv, input logic [3:0] val, input logic e, input logic c);
      load_valid = lv;
      load_value = val;
      en         = e;
      clr        = c;
   endtask

   task automatic chk(input string nm, input logic [3:0] o, input logic t, input logic b, input logic r);
      checks++;
      if (out !== o || tc !== t || busy !== b || load_ready !== r) begin
         errors++;
         $display("FAIL %s: got out=%0d tc=%0b busy=%0b ready=%0b, want out=%0d tc=%0b busy=%0b ready=%0b",
                  nm, out, tc, busy, load_ready, o, t, b, r);
      end
   endtask

   initial begin
      // load 5, count to zero, tc, ready back
      vt[0]  = '{1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0};
      vt[1]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0};
      vt[2]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0};
      vt[3]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0};
      vt[4]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
      vt[6]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
      // load 3 with en low, stray loads during RUN ignored
      vt[7]  = '{1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0};
      vt[8]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0};
      vt[9]  = '{1'b1, 4'd9, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0};
      vt[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0};
      vt[11] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0};
      vt[12] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0};
      vt[13] = '{1'b1, 4'd7, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
      vt[14] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
      vt[15] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
      // load 0 goes straight to DONE
      vt[16] = '{1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
      vt[17] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
      // load 6, clr at out=2, then clr+load in IDLE
      vt[18] = '{1'b1, 4'd6, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0};
      vt[19] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0};
      vt[20] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0};
      vt[21] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0};
      vt[22] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0};
      vt[23] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1};
      vt[24] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
      vt[25] = '{1'b1, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1};
      vt[26] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};

      drive(1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      chk("reset_async", 4'd0, 1'b0, 1'b0, 1'b1);
      repeat (4) step();
      chk("reset_held", 4'd0, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      step();
      chk("reset_release", 4'd0, 1'b0, 1'b0, 1'b1);

`ifndef AUTO_RELOAD_EN
      for (int i = 0; i < 27; i++) begin
         drive(vt[i].lv, vt[i].val, vt[i].en, vt[i].clr);
         step();
         chk($sformatf("vec%0d", i), vt[i].o, vt[i].t, vt[i].b, vt[i].r);
      end

      drive(1'b1, 4'd15, 1'b1, 1'b0);
      step();
      chk("max_load", 4'd15, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 1'b0);
      for (int m = 1; m <= 15; m++) begin
         step();
         chk($sformatf("max_dec%0d", m), 4'(15 - m), m == 15, 1'b1, 1'b0);
      end
      step();
      chk("max_idle", 4'd0, 1'b0, 1'b0, 1'b1);
      step();
      chk("max_nowrap", 4'd0, 1'b0, 1'b0, 1'b1);
`else
      drive(1'b1, 4'd2, 1'b1, 1'b0);
      step();
      chk("ar_load", 4'd2, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 1'b0);
      for (int m = 1; m <= 7; m++) begin
         step();
         chk($sformatf("ar_cyc%0d", m), 4'(2 - (m % 3)), (m % 3) == 2, 1'b1, 1'b0);
      end
      drive(1'b0, 4'd0, 1'b1, 1'b1);
      step();
      chk("ar_clr", 4'd0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 4'd0, 1'b1, 1'b0);
      step();
      chk("ar_zero_load", 4'd0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 1'b0);
      for (int m = 0; m < 3; m++) begin
         step();
         chk($sformatf("ar_zero_hold%0d", m), 4'd0, 1'b1, 1'b1, 1'b0);
      end
      drive(1'b0, 4'd0, 1'b1, 1'b1);
      step();
      chk("ar_zero_clr", 4'd0, 1'b0, 1'b0, 1'b1);
`endif

      drive(1'b1, 4'd9, 1'b1, 1'b0);
      step();
      chk("midrun_load", 4'd9, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 1'b0);
      step();
      chk("midrun_dec", 4'd8, 1'b0, 1'b1, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("midrun_async_rst", 4'd0, 1'b0, 1'b0, 1'b1);
      step();
      rst = 1'b1;
      step();
      chk("midrun_after_rst", 4'd0, 1'b0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
